// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: one request/response memory port (valid/ready, address, write data, strobes, read data).
// Latency: none, plain signal bundle.
// Backpressure: the requester holds valid and payload until ready pulses for one cycle.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 34,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    // Requesting side: issues address/data, receives completion
    modport master (
        output valid, wstrb, addr, wdata,
        input  ready, rdata
    );

    // Serving side: accepts the request, returns completion
    modport slave (
        input  valid, wstrb, addr, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction-side m0 and data-side m1.
// Latency: request seen at edge N drives mem_valid in cycle N+1; completion is returned combinationally with mem_ready.
// Backpressure: the non-granted master holds valid until served; a transfer with no mem_ready for TIMEOUT busy cycles is aborted.
module mem_port_arbiter #(
    parameter int ADDR_W     = 34,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 255,
    parameter int PRIO_FIXED = 0
) (
    input  logic               clk,
    input  logic               resetn,
    mem_port_arbiter_if.slave  m0,
    mem_port_arbiter_if.slave  m1,
    mem_port_arbiter_if.master mem,
    output logic               bus_err,
    output logic               err_master,
    output logic [31:0]        xfer_cnt0,
    output logic [31:0]        xfer_cnt1
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    logic              grant;
    logic              last_grant;
    logic [15:0]       tmo_cnt;
    logic              busy;
    logic              abort;
    logic              finish;
    logic              pick;
    logic              sel_m1;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] rdata_pass;

    // Winner of the next transaction; only consulted in IDLE when at least one master requests
    always_comb begin
        if (m0.valid && m1.valid) begin
            pick = (PRIO_FIXED != 0) ? 1'b0 : ~last_grant;
        end else begin
            pick = ~m0.valid;
        end
    end

    // Completion / timeout detection for the transfer in flight
    always_comb begin
        busy   = (state == BUSY);
        abort  = busy && !mem.ready && (tmo_cnt == 16'(TIMEOUT - 1));
        finish = (busy && mem.ready) || abort;
    end

    // Request mux toward memory (m0 when idle) and response steering to the granted master only
    always_comb begin
        sel_m1     = busy && grant;
        addr_mux   = sel_m1 ? m1.addr : m0.addr;
        mem.addr   = addr_mux;
        mem.wdata  = sel_m1 ? m1.wdata : m0.wdata;
        mem.wstrb  = sel_m1 ? m1.wstrb : m0.wstrb;
        mem.valid  = busy;
        rdata_pass = (busy && !abort) ? mem.rdata : '0;
        m0.ready   = finish && !grant;
        m1.ready   = finish && grant;
        m0.rdata   = grant ? '0 : rdata_pass;
        m1.rdata   = grant ? rdata_pass : '0;
        bus_err    = abort;
    end

    // Transaction FSM: grant in IDLE, complete or abort in BUSY; reset drops any transfer silently
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            tmo_cnt    <= '0;
            err_master <= 1'b0;
            xfer_cnt0  <= '0;
            xfer_cnt1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // stale mem_ready is ignored here; any valid starts a new transfer
                    if (m0.valid || m1.valid) begin
                        grant   <= pick;
                        tmo_cnt <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem.ready) begin
                        if (grant) begin
                            xfer_cnt1 <= xfer_cnt1 + 32'd1;
                        end else begin
                            xfer_cnt0 <= xfer_cnt0 + 32'd1;
                        end
                        last_grant <= grant;
                        state      <= IDLE;
                    end else if (abort) begin
                        err_master <= grant;
                        last_grant <= grant;
                        state      <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and a randomized run against a transaction model.
// Latency: inputs applied 1 time unit after the rising edge, outputs sampled 3 units after it.
// Backpressure: masters hold valid until their ready and drop it for at least one cycle afterwards.
module tb_mem_port_arbiter;
    localparam int AW  = 34;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fx_m0 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fx_m1 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fx_mem ();

    logic        bus_err, err_master;
    logic [31:0] xfer_cnt0, xfer_cnt1;
    logic        fx_bus_err, fx_err_master;
    logic [31:0] fx_xfer_cnt0, fx_xfer_cnt1;

    // fixed-priority instance sees exactly the same stimulus
    assign fx_m0.valid  = m0.valid;
    assign fx_m0.addr   = m0.addr;
    assign fx_m0.wdata  = m0.wdata;
    assign fx_m0.wstrb  = m0.wstrb;
    assign fx_m1.valid  = m1.valid;
    assign fx_m1.addr   = m1.addr;
    assign fx_m1.wdata  = m1.wdata;
    assign fx_m1.wstrb  = m1.wstrb;
    assign fx_mem.ready = mem.ready;
    assign fx_mem.rdata = mem.rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .PRIO_FIXED(0)) dut (
        .clk(clk), .resetn(resetn), .m0(m0), .m1(m1), .mem(mem),
        .bus_err(bus_err), .err_master(err_master),
        .xfer_cnt0(xfer_cnt0), .xfer_cnt1(xfer_cnt1)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .PRIO_FIXED(1)) dut_fx (
        .clk(clk), .resetn(resetn), .m0(fx_m0), .m1(fx_m1), .mem(fx_mem),
        .bus_err(fx_bus_err), .err_master(fx_err_master),
        .xfer_cnt0(fx_xfer_cnt0), .xfer_cnt1(fx_xfer_cnt1)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        m0.valid  = 1'b0; m0.addr = '0; m0.wdata = '0; m0.wstrb = '0;
        m1.valid  = 1'b0; m1.addr = '0; m1.wdata = '0; m1.wstrb = '0;
        mem.ready = 1'b0; mem.rdata = '0;
        tick();
        tick();
        resetn = 1'b1;
        #2;
        chk("rst mem_valid", mem.valid, 0);
        chk("rst m0_ready", m0.ready, 0);
        chk("rst m1_ready", m1.ready, 0);
        chk("rst bus_err", bus_err, 0);
        chk("rst err_master", err_master, 0);
        chk("rst xfer_cnt0", xfer_cnt0, 0);
        chk("rst xfer_cnt1", xfer_cnt1, 0);
        tick();
    endtask

    // one row per cycle from reset: {v0, v1, mem_ready} -> {mem_valid, m0_ready, m1_ready, bus_err, m0 passes rdata, m1 passes rdata, mem_addr from m1}
    typedef struct packed {
        bit v0, v1, mr;
        bit e_mv, e_r0, e_r1, e_err, e_p0, e_p1, e_asel;
    } vec_t;

    initial begin
        bit [9:0] tbl [11];
        vec_t v;
        // random-run model state
        bit   mb, mg, ml, merr;
        int   mk;
        int   mc [2];
        bit   pend [2];
        bit   cool [2];
        logic [AW-1:0] pa [2];
        logic [DW-1:0] pd [2];
        logic [3:0]    ps [2];
        bit            e_rdy [2];
        logic [DW-1:0] e_rd [2];
        bit            e_mv, e_err;

        tbl = '{10'b111_0000000, 10'b110_1000100, 10'b111_1100100, 10'b011_0000000,
                10'b111_1010011, 10'b100_0000000, 10'b111_1100100, 10'b000_0000000,
                10'b110_0000000, 10'b111_1010011, 10'b000_0000000};

        // ---- table-driven vectors (round-robin instance) ----
        do_reset();
        m0.addr = 34'h0A0;
        m1.addr = 34'h0B0;
        mem.rdata = 32'h55;
        for (int i = 0; i < 11; i++) begin
            v = vec_t'(tbl[i]);
            m0.valid  = v.v0;
            m1.valid  = v.v1;
            mem.ready = v.mr;
            #2;
            chk($sformatf("tbl%0d mem_valid", i), mem.valid, v.e_mv);
            chk($sformatf("tbl%0d m0_ready", i), m0.ready, v.e_r0);
            chk($sformatf("tbl%0d m1_ready", i), m1.ready, v.e_r1);
            chk($sformatf("tbl%0d bus_err", i), bus_err, v.e_err);
            chk($sformatf("tbl%0d m0_rdata", i), m0.rdata, v.e_p0 ? 32'h55 : 32'h0);
            chk($sformatf("tbl%0d m1_rdata", i), m1.rdata, v.e_p1 ? 32'h55 : 32'h0);
            chk($sformatf("tbl%0d mem_addr", i), mem.addr, v.e_asel ? 34'h0B0 : 34'h0A0);
            tick();
        end
        chk("tbl xfer_cnt0", xfer_cnt0, 2);
        chk("tbl xfer_cnt1", xfer_cnt1, 2);

        // ---- m0 read, memory answers after one busy cycle ----
        do_reset();
        m0.valid = 1'b1; m0.addr = 34'h1000; m0.wstrb = 4'h0;
        tick();
        #2;
        chk("rd mem_valid", mem.valid, 1);
        chk("rd mem_addr", mem.addr, 34'h1000);
        chk("rd mem_wstrb", mem.wstrb, 0);
        tick();
        mem.ready = 1'b1; mem.rdata = 32'h11223344;
        #2;
        chk("rd m0_ready", m0.ready, 1);
        chk("rd m0_rdata", m0.rdata, 32'h11223344);
        chk("rd m1_ready", m1.ready, 0);
        chk("rd m1_rdata", m1.rdata, 0);
        tick();
        m0.valid = 1'b0; mem.ready = 1'b0;
        #2;
        chk("rd m0_ready drop", m0.ready, 0);
        chk("rd xfer_cnt0", xfer_cnt0, 1);
        chk("rd xfer_cnt1", xfer_cnt1, 0);
        tick();

        // ---- m1 write while m0 waits ----
        m1.valid = 1'b1; m1.addr = 34'h3000; m1.wdata = 32'hDDCCBBAA; m1.wstrb = 4'hF;
        tick();
        m0.valid = 1'b1; m0.addr = 34'h1004;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("wr mem_addr", mem.addr, 34'h3000);
            chk("wr mem_wdata", mem.wdata, 32'hDDCCBBAA);
            chk("wr mem_wstrb", mem.wstrb, 4'hF);
            chk("wr m0 stalled", m0.ready, 0);
            tick();
        end
        mem.ready = 1'b1;
        #2;
        chk("wr m1_ready", m1.ready, 1);
        chk("wr m0_ready", m0.ready, 0);
        tick();
        m1.valid = 1'b0; mem.ready = 1'b0;
        #2;
        chk("wr idle gap", mem.valid, 0);
        tick();
        mem.ready = 1'b1; mem.rdata = 32'hCAFE0001;
        #2;
        chk("wr m0 granted", mem.addr, 34'h1004);
        chk("wr m0_ready", m0.ready, 1);
        chk("wr m0_rdata", m0.rdata, 32'hCAFE0001);
        tick();
        m0.valid = 1'b0; mem.ready = 1'b0;
        #2;
        chk("wr xfer_cnt0", xfer_cnt0, 2);
        chk("wr xfer_cnt1", xfer_cnt1, 1);
        tick();

        // ---- timeout on an m1 read ----
        m1.valid = 1'b1; m1.addr = 34'h5000; m1.wstrb = 4'h0;
        tick();
        mem.rdata = 32'hDEADBEEF;
        for (int k = 1; k <= TMO; k++) begin
            #2;
            chk($sformatf("tmo c%0d bus_err", k), bus_err, (k == TMO) ? 1 : 0);
            chk($sformatf("tmo c%0d m1_ready", k), m1.ready, (k == TMO) ? 1 : 0);
            chk($sformatf("tmo c%0d mem_valid", k), mem.valid, 1);
            if (k == TMO) begin
                chk("tmo m1_rdata", m1.rdata, 0);
                chk("tmo m0_ready", m0.ready, 0);
            end
            tick();
        end
        m1.valid = 1'b0;
        #2;
        chk("tmo bus_err pulse", bus_err, 0);
        chk("tmo err_master", err_master, 1);
        chk("tmo xfer_cnt1", xfer_cnt1, 1);
        chk("tmo idle", mem.valid, 0);
        m0.valid = 1'b1; m0.addr = 34'h2000;
        tick();
        mem.ready = 1'b1; mem.rdata = 32'h0000600D;
        #2;
        chk("tmo next addr", mem.addr, 34'h2000);
        chk("tmo next m0_ready", m0.ready, 1);
        chk("tmo next m0_rdata", m0.rdata, 32'h600D);
        chk("tmo next bus_err", bus_err, 0);
        tick();
        m0.valid = 1'b0; mem.ready = 1'b0;
        #2;
        chk("tmo xfer_cnt0", xfer_cnt0, 3);
        chk("tmo err_master held", err_master, 1);
        tick();

        // ---- asynchronous reset in the middle of a transfer ----
        m0.valid = 1'b1; m0.addr = 34'h7000;
        tick();
        #2;
        chk("ar busy", mem.valid, 1);
        mem.ready = 1'b1;
        resetn = 1'b0;
        #1;
        chk("ar mem_valid", mem.valid, 0);
        chk("ar m0_ready", m0.ready, 0);
        chk("ar bus_err", bus_err, 0);
        chk("ar xfer_cnt0", xfer_cnt0, 0);
        chk("ar xfer_cnt1", xfer_cnt1, 0);
        chk("ar err_master", err_master, 0);
        #2;
        resetn = 1'b1;
        mem.ready = 1'b0;
        #1;
        chk("ar still idle", mem.valid, 0);
        tick();
        #2;
        chk("ar regrant", mem.valid, 1);
        chk("ar regrant addr", mem.addr, 34'h7000);

        // ---- both masters requesting continuously: RR alternates, fixed keeps m0 ----
        do_reset();
        m0.addr = 34'h100; m1.addr = 34'h200;
        m0.valid = 1'b1; m1.valid = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            mem.ready = 1'b1;
            #2;
            chk($sformatf("rr%0d mem_addr", t), mem.addr, (t % 2 == 1) ? 34'h200 : 34'h100);
            chk($sformatf("rr%0d m0_ready", t), m0.ready, (t % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d m1_ready", t), m1.ready, (t % 2 == 1) ? 1 : 0);
            chk($sformatf("fx%0d m0_ready", t), fx_m0.ready, 1);
            chk($sformatf("fx%0d m1_ready", t), fx_m1.ready, 0);
            chk($sformatf("fx%0d mem_addr", t), fx_mem.addr, 34'h100);
            tick();
            mem.ready = 1'b0;
            #2;
            chk($sformatf("rr%0d idle gap", t), mem.valid, 0);
        end
        chk("rr xfer_cnt0", xfer_cnt0, 4);
        chk("rr xfer_cnt1", xfer_cnt1, 4);
        chk("fx xfer_cnt0", fx_xfer_cnt0, 8);
        chk("fx xfer_cnt1", fx_xfer_cnt1, 0);
        m0.valid = 1'b0;
        tick();
        mem.ready = 1'b1;
        #2;
        chk("fx m1 served", fx_m1.ready, 1);
        chk("fx m1 addr", fx_mem.addr, 34'h200);
        chk("fx bus_err", fx_bus_err, 0);
        chk("fx err_master", fx_err_master, 0);
        tick();
        m1.valid = 1'b0; mem.ready = 1'b0;

        // ---- randomized traffic against a transaction model ----
        do_reset();
        mb = 1'b0; mg = 1'b0; ml = 1'b1; merr = 1'b0; mk = 0;
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0; pend[i] = 1'b0; cool[i] = 1'b0;
            pa[i] = '0; pd[i] = '0; ps[i] = '0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && !cool[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    pa[i] = {2'($urandom_range(0, 3)), 32'($urandom)};
                    pd[i] = 32'($urandom);
                    ps[i] = 4'($urandom_range(0, 15));
                end
                cool[i] = 1'b0;
            end
            m0.valid = pend[0]; m0.addr = pa[0]; m0.wdata = pd[0]; m0.wstrb = ps[0];
            m1.valid = pend[1]; m1.addr = pa[1]; m1.wdata = pd[1]; m1.wstrb = ps[1];
            mem.ready = ($urandom_range(0, 3) == 0);
            mem.rdata = 32'($urandom);
            #2;
            chk("rnd xfer_cnt0", xfer_cnt0, mc[0]);
            chk("rnd xfer_cnt1", xfer_cnt1, mc[1]);
            chk("rnd err_master", err_master, merr);

            e_mv = mb; e_err = 1'b0;
            e_rdy[0] = 1'b0; e_rdy[1] = 1'b0;
            e_rd[0] = '0; e_rd[1] = '0;
            chk("rnd mem_addr", mem.addr, mb ? pa[mg] : pa[0]);
            if (mb) begin
                chk("rnd mem_wdata", mem.wdata, pd[mg]);
                chk("rnd mem_wstrb", mem.wstrb, ps[mg]);
                mk++;
                if (mem.ready) begin
                    e_rdy[mg] = 1'b1; e_rd[mg] = mem.rdata;
                    mc[mg]++; ml = mg; mb = 1'b0;
                end else if (mk == TMO) begin
                    e_rdy[mg] = 1'b1; e_err = 1'b1;
                    merr = mg; ml = mg; mb = 1'b0;
                end else begin
                    e_rd[mg] = mem.rdata;
                end
            end else if (pend[0] || pend[1]) begin
                mb = 1'b1; mk = 0;
                mg = (pend[0] && pend[1]) ? !ml : pend[1];
            end
            chk("rnd mem_valid", mem.valid, e_mv);
            chk("rnd m0_ready", m0.ready, e_rdy[0]);
            chk("rnd m1_ready", m1.ready, e_rdy[1]);
            chk("rnd m0_rdata", m0.rdata, e_rd[0]);
            chk("rnd m1_rdata", m1.rdata, e_rd[1]);
            chk("rnd bus_err", bus_err, e_err);
            for (int i = 0; i < 2; i++) begin
                if (e_rdy[i]) begin
                    pend[i] = 1'b0;
                    cool[i] = 1'b1;
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // hard stop if the sequence above ever stalls
    initial begin
        #1000000;
        $display("FAIL watchdog: run still active at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
